// File: rtl/zap_branch_predict_gshare_if.sv
// Fetch-to-predictor bundle for zap_branch_predict_gshare.
// Carries the fetch bundle and the resolved-branch update going in, and the
// registered bundle with its prediction and init status coming out.
//   master: drives fetch bundle and update request, observes the stage.
//   slave : the predictor stage itself.
interface zap_branch_predict_gshare_if #(
  parameter int unsigned IW        = 9,
  parameter int unsigned CTR_WIDTH = 2
);
  // Fetch bundle
  logic [31:0]          i_pc;
  logic [31:0]          i_inst;
  logic [31:0]          i_pc_plus_8;
  logic                 i_val;
  logic                 i_abt;
  // Resolved-branch update from the ALU
  logic                 i_upd_en;
  logic                 i_upd_taken;
  logic [IW-1:0]        i_upd_idx;
  logic [CTR_WIDTH-1:0] i_upd_ctr;
  // Registered bundle and prediction
  logic [31:0]          o_inst_ff;
  logic [31:0]          o_pc_plus_8_ff;
  logic [31:0]          o_pc_ff;
  logic                 o_val_ff;
  logic                 o_abt_ff;
  logic [CTR_WIDTH-1:0] o_ctr_ff;
  logic                 o_taken_ff;
  logic [IW-1:0]        o_idx_ff;
  logic                 o_init_busy;

  modport master (
    output i_pc, i_inst, i_pc_plus_8, i_val, i_abt,
           i_upd_en, i_upd_taken, i_upd_idx, i_upd_ctr,
    input  o_inst_ff, o_pc_plus_8_ff, o_pc_ff, o_val_ff, o_abt_ff,
           o_ctr_ff, o_taken_ff, o_idx_ff, o_init_busy
  );

  modport slave (
    input  i_pc, i_inst, i_pc_plus_8, i_val, i_abt,
           i_upd_en, i_upd_taken, i_upd_idx, i_upd_ctr,
    output o_inst_ff, o_pc_plus_8_ff, o_pc_ff, o_val_ff, o_abt_ff,
           o_ctr_ff, o_taken_ff, o_idx_ff, o_init_busy
  );
endinterface

// File: rtl/zap_branch_predict_gshare.sv
// Fetch-side branch predictor stage: registers the fetch bundle and attaches
// a prediction from a table of saturating counters. The table is swept to
// weakly-not-taken after reset and updated from the ALU with the index and
// counter snapshot captured at prediction time.
// Optional feature: define ZAP_BP_GSHARE_EN to hash the PC index with a
// global history register; otherwise the index is the plain PC index.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_clear_from_*            pipeline flushes (writeback > alu > decode)
//   i_data_stall, i_stall_*   stage holds
//   bp (slave)                fetch bundle, update request, registered outputs
module zap_branch_predict_gshare #(
  parameter int unsigned BP_ENTRIES = 512,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned GHR_WIDTH  = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear_from_writeback,
  input  logic i_clear_from_alu,
  input  logic i_clear_from_decode,
  input  logic i_data_stall,
  input  logic i_stall_from_shifter,
  input  logic i_stall_from_issue,
  input  logic i_stall_from_decode,
  zap_branch_predict_gshare_if.slave bp
);

  localparam int unsigned IW  = $clog2(BP_ENTRIES);
  localparam int unsigned CW1 = CTR_WIDTH + 1;
  localparam logic [CTR_WIDTH-1:0] WNT     = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } init_state_e;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_HOLD,
    OP_CLEAR
  } stage_op_e;

  init_state_e          state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 busy_c;
  logic                 upd_qual_c;
  logic [CW1-1:0]       inc_c, dec_c;
  logic [CTR_WIDTH-1:0] upd_val_c;
  logic [IW-1:0]        rd_idx_c;
  logic [CTR_WIDTH-1:0] rd_ctr_c;
  logic [CTR_WIDTH-1:0] ld_ctr_c;
  stage_op_e            op_c;
  logic [CTR_WIDTH-1:0] tbl_q [BP_ENTRIES];
  logic                 unused_pc_bits;

  // Init sweep state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Init sweep next-state: one entry per cycle, stalls and clears ignored
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_c  = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        busy_c = 1'b1;
        ptr_d  = ptr_q + IW'(1);
        if (ptr_q == IW'(BP_ENTRIES - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign bp.o_init_busy = (state_q == ST_SWEEP);

  assign upd_qual_c = bp.i_upd_en && !i_data_stall && !busy_c;

  // Saturating step, done one bit wider so wrap is visible in the top bit
  always_comb begin
    inc_c = {1'b0, bp.i_upd_ctr} + CW1'(1);
    dec_c = {1'b0, bp.i_upd_ctr} - CW1'(1);
    if (bp.i_upd_taken) begin
      upd_val_c = inc_c[CTR_WIDTH] ? CTR_MAX : inc_c[CTR_WIDTH-1:0];
    end else begin
      upd_val_c = dec_c[CTR_WIDTH] ? '0 : dec_c[CTR_WIDTH-1:0];
    end
  end

`ifdef ZAP_BP_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

  // History shifts only on updates that actually write the table
  generate
    if (GHR_WIDTH == 1) begin : g_ghr1
      assign ghr_d = bp.i_upd_taken;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GHR_WIDTH-2:0], bp.i_upd_taken};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ghr_q <= '0;
    end else if (upd_qual_c) begin
      ghr_q <= ghr_d;
    end
  end

  assign rd_idx_c = bp.i_pc[IW:1] ^ IW'(ghr_q);
`else
  assign rd_idx_c = bp.i_pc[IW:1];
`endif

  // Bit 0 is the Thumb halfword bit; upper bits alias across the table
  assign unused_pc_bits = ^{bp.i_pc[31:IW+1], bp.i_pc[0]};

  // Counter table: sweep has the write port exclusively while busy
  always_ff @(posedge i_clk) begin
    if (busy_c) begin
      tbl_q[ptr_q] <= WNT;
    end else if (upd_qual_c) begin
      tbl_q[bp.i_upd_idx] <= upd_val_c;
    end
  end

  // Read with same-cycle write bypass; table contents are meaningless mid-sweep
  always_comb begin
    rd_ctr_c = tbl_q[rd_idx_c];
    if (upd_qual_c && (bp.i_upd_idx == rd_idx_c)) begin
      rd_ctr_c = upd_val_c;
    end
    ld_ctr_c = busy_c ? WNT : rd_ctr_c;
  end

  // Stage action by flush/stall priority
  always_comb begin
    op_c = OP_LOAD;
    if (i_reset)                     op_c = OP_CLEAR;
    else if (i_clear_from_writeback) op_c = OP_CLEAR;
    else if (i_data_stall)           op_c = OP_HOLD;
    else if (i_clear_from_alu)       op_c = OP_CLEAR;
    else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode)
                                     op_c = OP_HOLD;
    else if (i_clear_from_decode)    op_c = OP_CLEAR;
  end

  // Stage registers
  always_ff @(posedge i_clk) begin
    if (op_c == OP_CLEAR) begin
      bp.o_inst_ff      <= '0;
      bp.o_pc_plus_8_ff <= 32'd8;
      bp.o_pc_ff        <= '0;
      bp.o_val_ff       <= 1'b0;
      bp.o_abt_ff       <= 1'b0;
      bp.o_ctr_ff       <= WNT;
      bp.o_taken_ff     <= 1'b0;
      bp.o_idx_ff       <= '0;
    end else if (op_c == OP_LOAD) begin
      bp.o_inst_ff      <= bp.i_inst;
      bp.o_pc_plus_8_ff <= bp.i_pc_plus_8;
      bp.o_pc_ff        <= bp.i_pc;
      bp.o_val_ff       <= bp.i_val;
      bp.o_abt_ff       <= bp.i_abt;
      bp.o_ctr_ff       <= ld_ctr_c;
      bp.o_taken_ff     <= ld_ctr_c[CTR_WIDTH-1];
      bp.o_idx_ff       <= rd_idx_c;
    end
  end

endmodule

// File: tb/tb_zap_branch_predict_gshare.sv
module tb_zap_branch_predict_gshare;

  localparam int unsigned ENT = 16;
  localparam int unsigned IW  = 4;
  localparam int unsigned GW  = 4;

  logic clk;
  logic rst;
  logic cwb, calu, cdec;
  logic dstall, sshift, sissue, sdec;

  int checks;
  int errors;
  int cnt;
  logic [3:0] gm;

  zap_branch_predict_gshare_if #(.IW(IW), .CTR_WIDTH(2)) bp0 ();
  zap_branch_predict_gshare_if #(.IW(IW), .CTR_WIDTH(3)) bp1 ();

  zap_branch_predict_gshare #(.BP_ENTRIES(ENT), .CTR_WIDTH(2), .GHR_WIDTH(GW)) u0 (
    .i_clk(clk), .i_reset(rst),
    .i_clear_from_writeback(cwb), .i_clear_from_alu(calu), .i_clear_from_decode(cdec),
    .i_data_stall(dstall), .i_stall_from_shifter(sshift),
    .i_stall_from_issue(sissue), .i_stall_from_decode(sdec),
    .bp(bp0)
  );

  zap_branch_predict_gshare #(.BP_ENTRIES(ENT), .CTR_WIDTH(3), .GHR_WIDTH(GW)) u1 (
    .i_clk(clk), .i_reset(rst),
    .i_clear_from_writeback(cwb), .i_clear_from_alu(calu), .i_clear_from_decode(cdec),
    .i_data_stall(dstall), .i_stall_from_shifter(sshift),
    .i_stall_from_issue(sissue), .i_stall_from_decode(sdec),
    .bp(bp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic [31:0] pc);
    bp0.i_pc = pc; bp0.i_inst = pc ^ 32'hDEAD0000; bp0.i_pc_plus_8 = pc + 32'd8;
    bp0.i_val = 1'b1; bp0.i_abt = 1'b0;
    bp1.i_pc = pc; bp1.i_inst = pc ^ 32'hDEAD0000; bp1.i_pc_plus_8 = pc + 32'd8;
    bp1.i_val = 1'b1; bp1.i_abt = 1'b0;
  endtask

  task automatic set_upd(input logic ue, input logic [3:0] ui, input logic ut,
                         input logic [1:0] c0, input logic [2:0] c1);
    bp0.i_upd_en = ue; bp0.i_upd_idx = ui; bp0.i_upd_taken = ut; bp0.i_upd_ctr = c0;
    bp1.i_upd_en = ue; bp1.i_upd_idx = ui; bp1.i_upd_taken = ut; bp1.i_upd_ctr = c1;
  endtask

  // One load cycle with an optional update; keeps the bench's history copy
  task automatic cyc(input logic [31:0] pc, input logic ue, input logic [3:0] ui,
                     input logic ut, input logic [1:0] c0, input logic [2:0] c1);
    drive_fetch(pc);
    set_upd(ue, ui, ut, c0, c1);
    tick();
`ifdef ZAP_BP_GSHARE_EN
    if (ue) gm = {gm[2:0], ut};
`endif
    set_upd(1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
  endtask

  // Read the entry at idx under the current history
  task automatic rd(input logic [3:0] idx);
    cyc({27'd0, idx ^ gm, 1'b0}, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
  endtask

  task automatic chk_pred(input string tag, input logic [3:0] idx,
                          input logic [1:0] e0, input logic [2:0] e1);
    chk({tag, "_idx"},    32'(bp0.o_idx_ff),   32'(idx));
    chk({tag, "_ctr0"},   32'(bp0.o_ctr_ff),   32'(e0));
    chk({tag, "_taken0"}, 32'(bp0.o_taken_ff), 32'(e0[1]));
    chk({tag, "_ctr1"},   32'(bp1.o_ctr_ff),   32'(e1));
    chk({tag, "_taken1"}, 32'(bp1.o_taken_ff), 32'(e1[2]));
  endtask

  initial begin
    checks = 0; errors = 0; gm = 4'd0;
    rst = 1'b1; cwb = 1'b0; calu = 1'b0; cdec = 1'b0;
    dstall = 1'b0; sshift = 1'b0; sissue = 1'b0; sdec = 1'b0;
    drive_fetch(32'h0000_0040);
    set_upd(1'b0, 4'd0, 1'b0, 2'd0, 3'd0);

    // Reset state
    tick(); tick();
    chk("rst_busy0", 32'(bp0.o_init_busy), 32'd1);
    chk("rst_busy1", 32'(bp1.o_init_busy), 32'd1);
    chk("rst_pc8",   bp0.o_pc_plus_8_ff, 32'd8);
    chk("rst_pc",    bp0.o_pc_ff, 32'd0);
    chk("rst_inst",  bp0.o_inst_ff, 32'd0);
    chk("rst_val",   32'(bp0.o_val_ff), 32'd0);
    chk("rst_abt",   32'(bp0.o_abt_ff), 32'd0);
    chk_pred("rst", 4'd0, 2'd1, 3'd3);

    // Sweep length; an update mid-sweep must be dropped
    rst = 1'b0;
    cnt = 0;
    while (bp0.o_init_busy && cnt < 40) begin
      set_upd(cnt == 10, 4'd0, 1'b1, 2'd3, 3'd7);
      tick();
      cnt++;
    end
    set_upd(1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    chk("sweep_len", 32'(cnt), 32'd16);
    chk("sweep_busy1", 32'(bp1.o_init_busy), 32'd0);

    // Every entry reads weakly-not-taken, history still zero
    for (int i = 0; i < 16; i++) begin
      cyc(32'(i) << 1, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
      chk_pred($sformatf("init%0d", i), 4'(i), 2'd1, 3'd3);
    end

    // Bypass: write idx 5 while reading pc 0x0A with empty history
    cyc(32'h0000_000A, 1'b1, 4'd5, 1'b1, 2'd2, 3'd6);
    chk_pred("bypass", 4'd5, 2'd3, 3'd7);
    chk("bypass_pc",   bp0.o_pc_ff, 32'h0000_000A);
    chk("bypass_pc8",  bp0.o_pc_plus_8_ff, 32'h0000_0012);
    chk("bypass_inst", bp0.o_inst_ff, 32'hDEAD000A);

    // Saturation up
    cyc(32'd0, 1'b1, 4'd3, 1'b1, 2'd3, 3'd7);
    rd(4'd3);
    chk_pred("sat_up", 4'd3, 2'd3, 3'd7);
    cyc(32'd0, 1'b1, 4'd4, 1'b1, 2'd1, 3'd3);
    rd(4'd4);
    chk_pred("inc", 4'd4, 2'd2, 3'd4);

    // Three taken updates so far: history 0x7
    cyc(32'h0000_0010, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
`ifdef ZAP_BP_GSHARE_EN
    chk("gshare_idx", 32'(bp0.o_idx_ff), 32'h0F);
`else
    chk("gshare_idx", 32'(bp0.o_idx_ff), 32'h08);
`endif

    // Saturation down
    cyc(32'd0, 1'b1, 4'd6, 1'b0, 2'd0, 3'd0);
    rd(4'd6);
    chk_pred("sat_dn", 4'd6, 2'd0, 3'd0);
    cyc(32'd0, 1'b1, 4'd7, 1'b0, 2'd2, 3'd4);
    rd(4'd7);
    chk_pred("dec", 4'd7, 2'd1, 3'd3);

    // Priority: data_stall beats clear_from_alu
    cyc(32'h0000_0100, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    dstall = 1'b1; calu = 1'b1;
    cyc(32'h0000_0200, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    chk("hold_pc",   bp0.o_pc_ff, 32'h0000_0100);
    chk("hold_val",  32'(bp0.o_val_ff), 32'd1);
    chk("hold_inst", bp0.o_inst_ff, 32'hDEAD0100);
    calu = 1'b0;

    // Priority: clear_from_writeback beats data_stall
    cwb = 1'b1;
    cyc(32'h0000_0300, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    chk("wb_pc8", bp0.o_pc_plus_8_ff, 32'd8);
    chk("wb_pc",  bp0.o_pc_ff, 32'd0);
    chk("wb_val", 32'(bp0.o_val_ff), 32'd0);
    cwb = 1'b0; dstall = 1'b0;

    // Priority: stall_from_decode beats clear_from_decode
    cyc(32'h0000_0300, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    sdec = 1'b1; cdec = 1'b1;
    cyc(32'h0000_0400, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    chk("dec_hold_pc", bp0.o_pc_ff, 32'h0000_0300);
    sdec = 1'b0;
    cyc(32'h0000_0500, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0);
    chk("dec_clr_pc",  bp0.o_pc_ff, 32'd0);
    chk("dec_clr_ctr", 32'(bp0.o_ctr_ff), 32'd1);
    cdec = 1'b0;

    // Clear and update in the same cycle both take effect
    calu = 1'b1;
    cyc(32'h0000_0500, 1'b1, 4'd9, 1'b1, 2'd2, 3'd5);
    chk("clrupd_pc", bp0.o_pc_ff, 32'd0);
    calu = 1'b0;
    rd(4'd9);
    chk_pred("clrupd", 4'd9, 2'd3, 3'd6);

    // Reset mid-sweep restarts the full sweep
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    gm = 4'd0;
    cnt = 0;
    while (bp0.o_init_busy && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("resweep_len", 32'(cnt), 32'd16);
    rd(4'd5);
    chk_pred("resweep", 4'd5, 2'd1, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
